cp_pingpong_ctrl: RTL
=====================

// Module: cp_pingpong_ctrl
// PURPOSE
// Sequencer for the CP-removal ping-pong sample buffer. Frames input samples into symbols, discards
// the cyclic prefix, and generates write enables/addresses into two NFFT-deep banks. Schedules
// read-out of full banks to the FFT and flags overruns. Sits between the ADC/sync front end and the FFT.
// PARAMETERS
// LCP   16  cyclic-prefix length in samples
// NFFT  48  useful samples per symbol (bank depth)
// AW    6   bank address width, 2**AW >= NFFT
// PORTS
// CLK_I      in   1   single clock for all logic
// RST_I      in   1   asynchronous, active-low reset
// DIN_I      in   1   input sample valid (one sample per asserted cycle)
// SYNC_I     in   1   symbol-start strobe, qualified by DIN_I; this sample becomes sample 0
// WR_EN_O    out  1   bank write enable (combinational from DIN_I and counter)
// WR_BANK_O  out  1   bank being written
// WR_ADDR_O  out  AW  write address within bank
// RD_RDY_I   in   1   FFT ready to accept a full symbol
// RD_BANK_O  out  1   bank being read
// RD_ADDR_O  out  AW  read address; sync RAM, data valid 1 cycle later
// DVAL_O     out  1   read data valid, aligned to RAM output
// SOP_O      out  1   with DVAL_O on first sample of symbol
// EOP_O      out  1   with DVAL_O on last sample of symbol
// FULL_O     out  2   per-bank full flags
// OVF_O      out  1   one-cycle pulse: symbol dropped, bank still full
// BEHAVIOUR
// Reset: all outputs 0; sample counter 0; WR_BANK_O=0, RD_BANK_O=0; FULL_O=2'b00; read FSM IDLE.
// Write side: counter cnt in 0..LCP+NFFT-1, advances on DIN_I, wraps to 0 after LCP+NFFT-1.
// - DIN_I&SYNC_I: sample taken as cnt=0, next cnt=1 (resync; a partial bank is abandoned, not marked full).
// - Window: WR_EN_O=DIN_I & (LCP<=cnt<LCP+NFFT) & ~drop; WR_ADDR_O=cnt-LCP; CP samples never written.
// - At cnt=0 with DIN_I: if FULL_O[WR_BANK_O] then drop=1 for whole symbol, OVF_O pulses that cycle.
// - Writing addr NFFT-1 (not dropped): set FULL_O[WR_BANK_O] next cycle, toggle WR_BANK_O.
// Read FSM states IDLE, READ, GAP:
// - IDLE -> READ when RD_RDY_I & FULL_O[RD_BANK_O]; RD_ADDR_O=0.
// - READ: RD_ADDR_O increments each cycle 0..NFFT-1 (RD_RDY_I ignored once started);
// after addr NFFT-1 -> GAP, clear FULL_O[RD_BANK_O], toggle RD_BANK_O.
// - GAP: one cycle, then IDLE (guaranteed 1-cycle bubble between symbols).
// - DVAL_O/SOP_O/EOP_O = READ-issue, addr==0, addr==NFFT-1, each delayed 1 cycle.
// Simultaneous set/clear: read release and write completion in same cycle both take effect.
// Overrun check at cnt=0 sees release of that same cycle (release has priority → no drop).
// Latency: last written sample to first DVAL_O = 3 cycles min (full flag, IDLE->READ, RAM).
// Reset mid-operation: immediate return to reset state; partial symbols and full flags discarded.
// CONFIGURATION
// CP_BACKOFF_EN defined: extra input BACKOFF_I[3:0]; window becomes LCP-B<=cnt<LCP-B+NFFT,
// B=min(BACKOFF_I,LCP) sampled at cnt=0; samples after window ignored.
// CP_BACKOFF_EN undefined: no port, B=0, behaviour as above.
// STRUCTURE
// Package cp_pkg: LCP, NFFT, AW defaults, SYMLEN=LCP+NFFT, read FSM state enum (IDLE/READ/GAP).
// Sub-module cp_rd_seq: read FSM + RD_ADDR_O + DVAL/SOP/EOP pipeline; write side and flags in top.
// TESTING
// 1 symbol, DIN_I 64 cycles from SYNC_I, RD_RDY_I=0 -> WR_EN_O on cnt16..63, addr 0..47, bank0, FULL_O=01.
// Raise RD_RDY_I -> 48 DVAL_O, SOP on first, EOP on 48th, RD_BANK_O->1, FULL_O=00, 1-cycle GAP.
// 3 back-to-back symbols, RD_RDY_I=0 -> symbols 1,2 fill banks 0,1; symbol 3 OVF_O pulse at its cnt0, no WR_EN_O.
// SYNC_I at cnt=30 -> bank0 not marked full, next write starts addr0 at cnt16 of new symbol, same bank.
// RST_I low mid-READ (addr 20) -> all outputs 0, FULL_O=00, FSM IDLE; clean symbol afterwards.
// CP_BACKOFF_EN, BACKOFF_I=4 -> WR_EN_O on cnt12..59, addr 0..47; BACKOFF_I=15 -> cnt1..48.

Source files
------------

// File: rtl/cp_pingpong_ctrl_pkg.sv
// Shared constants and read-sequencer state encoding for the CP-removal ping-pong buffer.
package cp_pkg;
  localparam int LCP_DEF    = 16;
  localparam int NFFT_DEF   = 48;
  localparam int AW_DEF     = 6;
  localparam int SYMLEN_DEF = LCP_DEF + NFFT_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } rd_state_e;
endpackage

// File: rtl/cp_pingpong_ctrl_if.sv
// Sample-stream and bank-control signals of the ping-pong controller.
// Optional CP_BACKOFF_EN adds BACKOFF_I.
interface cp_pingpong_ctrl_if #(parameter int AW = cp_pkg::AW_DEF);
  logic          DIN_I;
  logic          SYNC_I;
  logic          RD_RDY_I;
`ifdef CP_BACKOFF_EN
  logic [3:0]    BACKOFF_I;
`endif
  logic          WR_EN_O;
  logic          WR_BANK_O;
  logic [AW-1:0] WR_ADDR_O;
  logic          RD_BANK_O;
  logic [AW-1:0] RD_ADDR_O;
  logic          DVAL_O;
  logic          SOP_O;
  logic          EOP_O;
  logic [1:0]    FULL_O;
  logic          OVF_O;

  modport slave (
`ifdef CP_BACKOFF_EN
    input  BACKOFF_I,
`endif
    input  DIN_I, SYNC_I, RD_RDY_I,
    output WR_EN_O, WR_BANK_O, WR_ADDR_O, RD_BANK_O, RD_ADDR_O,
    output DVAL_O, SOP_O, EOP_O, FULL_O, OVF_O
  );

  modport master (
`ifdef CP_BACKOFF_EN
    output BACKOFF_I,
`endif
    output DIN_I, SYNC_I, RD_RDY_I,
    input  WR_EN_O, WR_BANK_O, WR_ADDR_O, RD_BANK_O, RD_ADDR_O,
    input  DVAL_O, SOP_O, EOP_O, FULL_O, OVF_O
  );
endinterface

// File: rtl/cp_pingpong_ctrl_rd_seq.sv
// Read sequencer: streams one full bank to the FFT, then a one-cycle gap before the next bank.
module cp_rd_seq
  import cp_pkg::*;
#(
  parameter int NFFT = cp_pkg::NFFT_DEF,
  parameter int AW   = cp_pkg::AW_DEF
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          i_rd_rdy,
  input  logic [1:0]    i_full,
  output logic          o_rd_bank,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_dval,
  output logic          o_sop,
  output logic          o_eop,
  output logic          o_release
);
  localparam logic [1:0]    ST_IDLE = IDLE;
  localparam logic [1:0]    ST_READ = READ;
  localparam logic [1:0]    ST_GAP  = GAP;
  localparam logic [AW-1:0] LAST    = AW'(NFFT - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic          r_bank;
  logic          r_dval, r_sop, r_eop;
  logic          w_issue, w_last;

  assign w_issue = (r_state == ST_READ);
  assign w_last  = w_issue && (r_addr == LAST);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_bank  <= 1'b0;
      r_dval  <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else begin
      // Flags trail the address by one cycle to line up with synchronous RAM data.
      r_dval <= w_issue;
      r_sop  <= w_issue && (r_addr == '0);
      r_eop  <= w_last;
      case (r_state)
        ST_IDLE: begin
          r_addr <= '0;
          if (i_rd_rdy && i_full[r_bank]) r_state <= ST_READ;
        end
        ST_READ: begin
          if (w_last) begin
            r_state <= ST_GAP;
            r_addr  <= '0;
            r_bank  <= ~r_bank;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_bank = r_bank;
  assign o_rd_addr = r_addr;
  assign o_dval    = r_dval;
  assign o_sop     = r_sop;
  assign o_eop     = r_eop;
  assign o_release = w_last;
endmodule

// File: rtl/cp_pingpong_ctrl.sv
// CP-removal ping-pong sequencer: frames samples into symbols, writes useful samples into two banks,
// hands full banks to cp_rd_seq. Optional CP_BACKOFF_EN shifts the write window earlier into the CP.
module cp_pingpong_ctrl
  import cp_pkg::*;
#(
  parameter int LCP  = cp_pkg::LCP_DEF,
  parameter int NFFT = cp_pkg::NFFT_DEF,
  parameter int AW   = cp_pkg::AW_DEF
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  cp_pingpong_ctrl_if.slave  bus
);
  localparam int SYMLEN = LCP + NFFT;
  localparam int CW     = $clog2(SYMLEN + 1);

  logic [CW-1:0] r_cnt, r_b;
  logic          r_drop, r_wr_bank;
  logic [1:0]    r_full;
  logic [CW-1:0] w_cnt, w_b_in, w_b, w_lo, w_off;
  logic [1:0]    w_rel_mask, w_set_mask, w_full_eff;
  logic          w_sym0, w_in_win, w_drop, w_wr_en, w_done, w_ovf, w_release, w_rd_bank;

  // A SYNC_I-qualified sample restarts the symbol at count 0.
  assign w_cnt  = (bus.DIN_I && bus.SYNC_I) ? '0 : r_cnt;
  assign w_sym0 = bus.DIN_I && (w_cnt == '0);

`ifdef CP_BACKOFF_EN
  assign w_b_in = (CW'(bus.BACKOFF_I) > CW'(LCP)) ? CW'(LCP) : CW'(bus.BACKOFF_I);
`else
  assign w_b_in = '0;
`endif

  assign w_b      = w_sym0 ? w_b_in : r_b;
  assign w_lo     = CW'(LCP) - w_b;
  assign w_off    = w_cnt - w_lo;
  assign w_in_win = (w_cnt >= w_lo) && (w_off < CW'(NFFT));

  // A bank released by the reader this cycle counts as free for the overrun decision.
  assign w_rel_mask = w_release ? (w_rd_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_eff = r_full & ~w_rel_mask;
  assign w_ovf      = w_sym0 && w_full_eff[r_wr_bank];
  assign w_drop     = w_sym0 ? w_full_eff[r_wr_bank] : r_drop;

  assign w_wr_en    = bus.DIN_I && w_in_win && !w_drop;
  assign w_done     = w_wr_en && (w_off == CW'(NFFT - 1));
  assign w_set_mask = w_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_cnt     <= '0;
      r_b       <= '0;
      r_drop    <= 1'b0;
      r_wr_bank <= 1'b0;
      r_full    <= 2'b00;
    end else begin
      if (bus.DIN_I) r_cnt <= (w_cnt == CW'(SYMLEN - 1)) ? '0 : w_cnt + 1'b1;
      if (w_sym0) begin
        r_b    <= w_b_in;
        r_drop <= w_full_eff[r_wr_bank];
      end
      if (w_done) r_wr_bank <= ~r_wr_bank;
      r_full <= (r_full & ~w_rel_mask) | w_set_mask;
    end
  end

  cp_rd_seq #(.NFFT(NFFT), .AW(AW)) u_rd_seq (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .i_rd_rdy  (bus.RD_RDY_I),
    .i_full    (r_full),
    .o_rd_bank (w_rd_bank),
    .o_rd_addr (bus.RD_ADDR_O),
    .o_dval    (bus.DVAL_O),
    .o_sop     (bus.SOP_O),
    .o_eop     (bus.EOP_O),
    .o_release (w_release)
  );

  assign bus.WR_EN_O   = w_wr_en;
  assign bus.WR_BANK_O = r_wr_bank;
  assign bus.WR_ADDR_O = w_in_win ? w_off[AW-1:0] : '0;
  assign bus.RD_BANK_O = w_rd_bank;
  assign bus.FULL_O    = r_full;
  assign bus.OVF_O     = w_ovf;
endmodule
